// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline stage-sequencing controller: register
// update commands, op classes, controller states and the register-match rule.
package pipe_pkg;

    localparam logic [1:0] UPD_HOLD  = 2'b00;
    localparam logic [1:0] UPD_ADV   = 2'b01;
    localparam logic [1:0] UPD_FLUSH = 2'b10;

    localparam logic [1:0] OP_LOAD   = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BUSY = 2'd1,
        HALT = 2'd2
    } pstate_t;

    // Same rule forwarding uses: a write (rw != 0) to the same file and index.
    function automatic logic reg_match(input logic [1:0] rw,
                                       input logic [4:0] rd,
                                       input logic [5:0] r);
        return (rw != 2'b00) && (rw[1] == r[5]) && (rd == r[4:0]);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: the E-stage load writes a register that
// the D-stage instruction reads.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [5:0] d_rs_i,
    input  logic [5:0] d_rt_i,
    input  logic       d_use_s_i,
    input  logic       d_use_t_i,
    input  logic [1:0] de_op_type_i,
    input  logic [1:0] de_rw_i,
    input  logic [4:0] de_rd_i,
    output logic       load_use_o
);

    logic s_hit;
    logic t_hit;

    assign s_hit      = d_use_s_i && reg_match(de_rw_i, de_rd_i, d_rs_i);
    assign t_hit      = d_use_t_i && reg_match(de_rw_i, de_rd_i, d_rt_i);
    assign load_use_o = (de_op_type_i == OP_LOAD) && (s_hit || t_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stage-sequencing controller: each cycle picks hold/advance/flush for the
// F/D, D/E and E/W registers plus PC write enable and select.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int WAIT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        d_rs,
    input  logic [5:0]        d_rt,
    input  logic              d_use_s,
    input  logic              d_use_t,
    input  logic [1:0]        de_op_type,
    input  logic [1:0]        de_rw,
    input  logic [4:0]        de_rd,
    input  logic [WAIT_W-1:0] de_wait_time,
    input  logic              de_stop,
    input  logic              e_redirect,
    input  logic              resume,
    output logic [1:0]        fd_update,
    output logic [1:0]        de_update,
    output logic [1:0]        ew_update,
    output logic              pc_we,
    output logic              pc_sel,
    output logic              halted
);

    localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

    pstate_t           state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              load_use;

    hazard_detect u_hazard (
        .d_rs_i       (d_rs),
        .d_rt_i       (d_rt),
        .d_use_s_i    (d_use_s),
        .d_use_t_i    (d_use_t),
        .de_op_type_i (de_op_type),
        .de_rw_i      (de_rw),
        .de_rd_i      (de_rd),
        .load_use_o   (load_use)
    );

    // Every branch after the two occupancy branches is a release cycle, so
    // stop/redirect/load-use are only ever looked at when E is vacating.
    always_comb begin
        fd_update = UPD_HOLD;
        de_update = UPD_HOLD;
        ew_update = UPD_HOLD;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        halted    = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        if (rst) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == HALT) begin
            halted = 1'b1;
            if (resume) begin
                state_d = RUN;
            end
        end else if (state_q == RUN && de_wait_time != '0) begin
            ew_update = UPD_FLUSH;
            cnt_d     = de_wait_time - CNT_ONE;
            state_d   = BUSY;
        end else if (state_q == BUSY && cnt_q != '0) begin
            ew_update = UPD_FLUSH;
            cnt_d     = cnt_q - CNT_ONE;
        end else if (de_stop) begin
            de_update = UPD_FLUSH;
            ew_update = UPD_ADV;
            state_d   = HALT;
        end else if (e_redirect) begin
            fd_update = UPD_FLUSH;
            de_update = UPD_FLUSH;
            ew_update = UPD_ADV;
            pc_we     = 1'b1;
            pc_sel    = 1'b1;
            state_d   = RUN;
        end else if (load_use) begin
            de_update = UPD_FLUSH;
            ew_update = UPD_ADV;
            state_d   = RUN;
        end else begin
            fd_update = UPD_ADV;
            de_update = UPD_ADV;
            ew_update = UPD_ADV;
            pc_we     = 1'b1;
            state_d   = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: the driver pushes the expected output word
// for each cycle, a negedge monitor pops and compares it.
module tb_pipe_ctrl;

    localparam int WAIT_W = 5;

    // Expected word: {fd, de, ew, pc_we, pc_sel, halted}
    localparam logic [8:0] E_RST   = 9'b00_00_00_0_0_0;
    localparam logic [8:0] E_ADV   = 9'b01_01_01_1_0_0;
    localparam logic [8:0] E_BUSY  = 9'b00_00_10_0_0_0;
    localparam logic [8:0] E_LU    = 9'b00_10_01_0_0_0;
    localparam logic [8:0] E_REDIR = 9'b10_10_01_1_1_0;
    localparam logic [8:0] E_STOP  = 9'b00_10_01_0_0_0;
    localparam logic [8:0] E_HALT  = 9'b00_00_00_0_0_1;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        d_rs, d_rt;
    logic              d_use_s, d_use_t;
    logic [1:0]        de_op_type, de_rw;
    logic [4:0]        de_rd;
    logic [WAIT_W-1:0] de_wait_time;
    logic              de_stop, e_redirect, resume;
    logic [1:0]        fd_update, de_update, ew_update;
    logic              pc_we, pc_sel, halted;

    logic [8:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.WAIT_W(WAIT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_use_s      (d_use_s),
        .d_use_t      (d_use_t),
        .de_op_type   (de_op_type),
        .de_rw        (de_rw),
        .de_rd        (de_rd),
        .de_wait_time (de_wait_time),
        .de_stop      (de_stop),
        .e_redirect   (e_redirect),
        .resume       (resume),
        .fd_update    (fd_update),
        .de_update    (de_update),
        .ew_update    (ew_update),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .halted       (halted)
    );

    // Monitor
    always @(negedge clk) begin
        logic [8:0] got;
        logic [8:0] e;
        string      n;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            got = {fd_update, de_update, ew_update, pc_we, pc_sel, halted};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got fd/de/ew/we/sel/h=%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b",
                         n, got[8:7], got[6:5], got[4:3], got[2], got[1], got[0],
                         e[8:7], e[6:5], e[4:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic cyc(input logic [8:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_rs = 6'd0; d_rt = 6'd0; d_use_s = 1'b0; d_use_t = 1'b0;
        de_op_type = 2'b00; de_rw = 2'b00; de_rd = 5'd0;
        de_wait_time = '0; de_stop = 1'b0; e_redirect = 1'b0; resume = 1'b0;
    endtask

    task automatic set_load(input logic [1:0] rw, input logic [4:0] rd);
        de_op_type = 2'b10; de_rw = rw; de_rd = rd;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        cyc(E_RST, "reset_out0");
        cyc(E_RST, "reset_out1");
        rst = 1'b0;
        cyc(E_ADV, "idle_adv");

        // Multi-cycle execute: wait 3 -> 3 bubbles then release.
        de_wait_time = 5'd3;
        for (int i = 0; i < 3; i++) cyc(E_BUSY, "wait3_busy");
        cyc(E_ADV, "wait3_release");
        idle_inputs();
        cyc(E_ADV, "after_wait3");

        // Load-use on s, same register file.
        set_load(2'b01, 5'd7); d_rs = 6'd7; d_use_s = 1'b1;
        cyc(E_LU, "lu_s_stall");
        idle_inputs(); d_rs = 6'd7; d_use_s = 1'b1;
        cyc(E_ADV, "lu_s_after");
        set_load(2'b01, 5'd7); d_rs = 6'h27; d_use_s = 1'b1;
        cyc(E_ADV, "lu_other_file");
        set_load(2'b10, 5'd7); d_rs = 6'd0; d_rt = 6'h27; d_use_t = 1'b1;
        cyc(E_LU, "lu_t_file1");
        d_use_t = 1'b0;
        cyc(E_ADV, "lu_t_unused");
        de_rw = 2'b00; d_use_t = 1'b1; d_rt = 6'd7;
        cyc(E_ADV, "lu_no_write");
        set_load(2'b01, 5'd7); de_op_type = 2'b01;
        cyc(E_ADV, "lu_not_load");
        idle_inputs();

        // Redirect immediately and after occupancy.
        e_redirect = 1'b1;
        cyc(E_REDIR, "redir_w0");
        de_wait_time = 5'd2;
        cyc(E_BUSY, "redir_w2_ign0");
        cyc(E_BUSY, "redir_w2_ign1");
        cyc(E_REDIR, "redir_w2_rel");
        de_wait_time = '0;
        set_load(2'b01, 5'd3); d_rs = 6'd3; d_use_s = 1'b1;
        cyc(E_REDIR, "redir_over_lu");
        idle_inputs();

        // Load-use ignored while busy, honoured at release.
        de_wait_time = 5'd1; set_load(2'b01, 5'd9); d_rt = 6'd9; d_use_t = 1'b1;
        cyc(E_BUSY, "lu_busy_ign");
        cyc(E_LU, "lu_busy_rel");
        idle_inputs();

        // Stop beats redirect, then halt and resume.
        de_stop = 1'b1; e_redirect = 1'b1;
        cyc(E_STOP, "stop_redir");
        idle_inputs();
        cyc(E_HALT, "halt0");
        e_redirect = 1'b1; de_wait_time = 5'd4;
        cyc(E_HALT, "halt_ign_inputs");
        idle_inputs(); resume = 1'b1;
        cyc(E_HALT, "halt_resume");
        resume = 1'b0;
        cyc(E_ADV, "after_resume");

        // Maximum wait: 31 bubbles then release.
        de_wait_time = 5'd31;
        for (int i = 0; i < 31; i++) cyc(E_BUSY, "wmax_busy");
        cyc(E_ADV, "wmax_release");
        idle_inputs();
        cyc(E_ADV, "after_wmax");

        // Reset while busy with cnt=5.
        de_wait_time = 5'd7;
        cyc(E_BUSY, "rb_load");
        cyc(E_BUSY, "rb_dec");
        rst = 1'b1;
        cyc(E_RST, "rb_reset");
        rst = 1'b0; de_wait_time = '0;
        cyc(E_ADV, "rb_run");

        // Reset while halted.
        de_stop = 1'b1;
        cyc(E_STOP, "rh_stop");
        de_stop = 1'b0;
        cyc(E_HALT, "rh_halt");
        rst = 1'b1; resume = 1'b0;
        cyc(E_RST, "rh_reset");
        rst = 1'b0;
        cyc(E_ADV, "rh_run");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
